lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 165 ++++++++++++++++
 tb/tb_lsu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one access at a time over a single-beat bus, with byte-lane steering and load extension.
// Optional macro LSU_MISALIGN_EN: misaligned accesses run as one or two beats instead of being rejected.
module lsu #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wstrb,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic [1:0]        dbg_state
);
    // Handshakes: a request transfers on req_valid && req_ready, a bus beat on
    // bus_valid && bus_ready; bus_* stay frozen while waiting. resp_valid is a
    // single-cycle pulse that the consumer cannot stall.
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_t;
    state_t state, state_next;

    logic            we_q, uns_q, err_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q, wdata_q, lo_q, rdata_q;

    logic              req_fire, req_illegal, split, last_beat, sign;
    int                nb, sh;
    logic [OW-1:0]     off;
    logic [XLEN-1:0]   base_addr, data_keep, rd_shifted, rd_ext;
    logic [NB-1:0]     strb_keep;
    logic [2*XLEN-1:0] wide_wdata, rd_joined;
    logic [2*NB-1:0]   wide_strb;

`ifdef LSU_MISALIGN_EN
    assign req_illegal = (XLEN == 32) && (req_size == 2'b11);
`else
    logic [2:0] align_mask;
    always_comb begin
        align_mask = 3'b000;
        case (req_size)
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            2'b11:   align_mask = 3'b111;
            default: align_mask = 3'b000;
        endcase
    end
    assign req_illegal = ((XLEN == 32) && (req_size == 2'b11)) || (|(req_addr[2:0] & align_mask));
`endif

    assign req_fire  = req_valid && (state == IDLE);
    assign last_beat = bus_ready && (((state == BEAT0) && !split) || (state == BEAT1));

    // Lane steering works on a double-width window so a split access is just
    // the upper half of the same shift.
    always_comb begin
        nb         = 1 << size_q;
        off        = addr_q[OW-1:0];
        sh         = 8 * int'(off);
        base_addr  = {addr_q[XLEN-1:OW], {OW{1'b0}}};
        data_keep  = (8 * nb >= XLEN) ? '1 : ({XLEN{1'b1}} >> (XLEN - 8 * nb));
        strb_keep  = (nb >= NB) ? '1 : ({NB{1'b1}} >> (NB - nb));
        wide_wdata = {{XLEN{1'b0}}, wdata_q & data_keep} << sh;
        wide_strb  = {{NB{1'b0}}, strb_keep} << off;
`ifdef LSU_MISALIGN_EN
        split      = (int'(off) + nb) > NB;
`else
        split      = 1'b0;
`endif
        rd_joined  = split ? {bus_rdata, lo_q} : {{XLEN{1'b0}}, bus_rdata};
        rd_shifted = XLEN'(rd_joined >> sh);
        case (size_q)
            2'b00:   sign = rd_shifted[7];
            2'b01:   sign = rd_shifted[15];
            2'b10:   sign = rd_shifted[31];
            default: sign = rd_shifted[XLEN-1];
        endcase
        rd_ext = (rd_shifted & data_keep) | ((!uns_q && sign) ? ~data_keep : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_illegal ? RESP : BEAT0;
            BEAT0:   if (bus_ready) state_next = split ? BEAT1 : RESP;
            BEAT1:   if (bus_ready) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (req_fire) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_illegal;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
            end
            if ((state == BEAT0) && bus_ready && split) lo_q <= bus_rdata;
            if (last_beat && !we_q) rdata_q <= rd_ext;
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q) ? rdata_q : '0;
        bus_valid  = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_wstrb  = '0;
        if (state == BEAT0) begin
            bus_valid = 1'b1;
            bus_we    = we_q;
            bus_addr  = base_addr;
            if (we_q) begin
                bus_wdata = wide_wdata[XLEN-1:0];
                bus_wstrb = wide_strb[NB-1:0];
            end
        end else if (state == BEAT1) begin
            bus_valid = 1'b1;
            bus_we    = we_q;
            bus_addr  = base_addr + XLEN'(NB);
            if (we_q) begin
                bus_wdata = wide_wdata[2*XLEN-1:XLEN];
                bus_wstrb = wide_strb[2*NB-1:NB];
            end
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table for 64-bit accesses, hand sequences for reset and XLEN=32.
module tb_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_we = 0, req_unsigned = 0, bus_ready = 0;
    logic [1:0]  req_size = 0;
    logic [63:0] req_addr = 0, req_wdata = 0, bus_rdata = 0;
    logic        req_ready, resp_valid, resp_err, bus_valid, bus_we;
    logic [63:0] resp_rdata, bus_addr, bus_wdata;
    logic [7:0]  bus_wstrb;
    logic [1:0]  dbg_state;

    logic        s_req_valid = 0, s_req_we = 0, s_req_unsigned = 0, s_bus_ready = 0;
    logic [1:0]  s_req_size = 0;
    logic [31:0] s_req_addr = 0, s_req_wdata = 0, s_bus_rdata = 0;
    logic        s_req_ready, s_resp_valid, s_resp_err, s_bus_valid, s_bus_we;
    logic [31:0] s_resp_rdata, s_bus_addr, s_bus_wdata;
    logic [3:0]  s_bus_wstrb;
    logic [1:0]  s_dbg_state;

    lsu #(.XLEN(64)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
    );

    lsu #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
        .req_size(s_req_size), .req_unsigned(s_req_unsigned), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata), .resp_err(s_resp_err),
        .bus_valid(s_bus_valid), .bus_ready(s_bus_ready), .bus_we(s_bus_we), .bus_addr(s_bus_addr),
        .bus_wdata(s_bus_wdata), .bus_wstrb(s_bus_wstrb), .bus_rdata(s_bus_rdata), .dbg_state(s_dbg_state)
    );

    typedef struct {
        logic            we;
        logic [1:0]      size;
        logic            uns;
        logic [63:0]     addr;
        logic [63:0]     wdata;
        int              waits;
        logic            err;
        int              beats;
        logic [1:0][63:0] b_addr;
        logic [1:0][7:0]  b_strb;
        logic [1:0][63:0] b_wdata;
        logic [1:0][63:0] b_rdata;
        logic [63:0]     rdata;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata, input int waits,
                                input logic err, input int beats,
                                input logic [63:0] a0, input logic [7:0] s0, input logic [63:0] w0, input logic [63:0] r0,
                                input logic [63:0] a1, input logic [7:0] s1, input logic [63:0] w1, input logic [63:0] r1,
                                input logic [63:0] rdata);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.waits = waits; v.err = err; v.beats = beats;
        v.b_addr[0] = a0; v.b_strb[0] = s0; v.b_wdata[0] = w0; v.b_rdata[0] = r0;
        v.b_addr[1] = a1; v.b_strb[1] = s1; v.b_wdata[1] = w1; v.b_rdata[1] = r1;
        v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, beat, waits_left;
        bit done;
        @(negedge clk);
        chk("req_ready_idle", idx, 64'(req_ready), 64'd1);
        req_valid = 1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        cyc = 1; beat = 0; waits_left = v.waits; done = 0;
        while (!done && cyc <= 20) begin
            if (resp_valid) begin
                chk("resp_err", idx, 64'(resp_err), 64'(v.err));
                chk("resp_rdata", idx, resp_rdata, v.rdata);
                chk("resp_bus_idle", idx, 64'(bus_valid), 64'd0);
                chk("beat_count", idx, 64'(beat), 64'(v.beats));
                chk("resp_cycle", idx, 64'(cyc), 64'(1 + v.waits + v.beats));
                done = 1;
            end else if (bus_valid) begin
                if (beat < v.beats) begin
                    chk("bus_addr", idx, bus_addr, v.b_addr[beat]);
                    chk("bus_we", idx, 64'(bus_we), 64'(v.we));
                    chk("bus_wstrb", idx, 64'(bus_wstrb), 64'(v.b_strb[beat]));
                    chk("bus_wdata", idx, bus_wdata, v.b_wdata[beat]);
                end else begin
                    chk("unexpected_beat", idx, 64'(beat + 1), 64'(v.beats));
                end
                if (waits_left > 0) begin
                    waits_left--;
                    bus_ready = 0;
                end else begin
                    bus_ready = 1;
                    bus_rdata = (beat < 2) ? v.b_rdata[beat] : 64'd0;
                    beat++;
                end
                @(posedge clk);
                @(negedge clk);
                bus_ready = 0; bus_rdata = 0;
                cyc++;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) chk("resp_timeout", idx, 64'd0, 64'd1);
        @(negedge clk);
        chk("resp_pulse_end", idx, 64'(resp_valid), 64'd0);
        chk("rdata_idle_zero", idx, resp_rdata, 64'd0);
        chk("err_idle_zero", idx, 64'(resp_err), 64'd0);
    endtask

    initial begin
        // 64-bit vectors: we,size,uns,addr,wdata,waits,err,beats, beat0{addr,strb,wdata,rdata}, beat1{...}, rdata
        vecs.push_back(mk(0, 2'd0, 0, 64'h13, 0, 0, 0, 1, 64'h10, 0, 0, 64'h0000_0000_8000_0000, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80));
        vecs.push_back(mk(1, 2'd1, 0, 64'h0A, 64'hBEEF, 0, 0, 1, 64'h08, 8'h0C, 64'h0000_0000_BEEF_0000, 64'h1234, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'd2, 0, 64'h20, 0, 3, 0, 1, 64'h20, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 64'hFFFF_FFFF_89AB_CDEF));
        vecs.push_back(mk(0, 2'd1, 1, 64'h06, 0, 0, 0, 1, 64'h00, 0, 0, 64'h8001_0000_0000_0000, 0, 0, 0, 0, 64'h8001));
        vecs.push_back(mk(0, 2'd3, 0, 64'h18, 0, 0, 0, 1, 64'h18, 0, 0, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 0, 0, 64'hDEAD_BEEF_0BAD_F00D));
        vecs.push_back(mk(1, 2'd3, 0, 64'h08, 64'h1122_3344_5566_7788, 0, 0, 1, 64'h08, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd0, 0, 64'h07, 64'h5A, 0, 0, 1, 64'h00, 8'h80, 64'h5A00_0000_0000_0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'd2, 1, 64'h0C, 0, 0, 0, 1, 64'h08, 0, 0, 64'h8765_4321_0000_0000, 0, 0, 0, 0, 64'h8765_4321));
        vecs.push_back(mk(0, 2'd0, 1, 64'h01, 0, 0, 0, 1, 64'h00, 0, 0, 64'h0000_0000_0000_FF00, 0, 0, 0, 0, 64'hFF));
`ifdef LSU_MISALIGN_EN
        vecs.push_back(mk(0, 2'd2, 1, 64'h0E, 0, 1, 0, 2, 64'h08, 0, 0, 64'hAABB_0000_0000_0000,
                          64'h10, 0, 0, 64'h1111_2222_0000_DDCC, 64'hDDCC_AABB));
        vecs.push_back(mk(0, 2'd1, 0, 64'h03, 0, 0, 0, 1, 64'h00, 0, 0, 64'h0000_0080_0100_0000, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_8001));
        vecs.push_back(mk(1, 2'd2, 0, 64'h0E, 64'hCAFE_BABE, 0, 0, 2, 64'h08, 8'hC0, 64'hBABE_0000_0000_0000, 0,
                          64'h10, 8'h03, 64'h0000_0000_0000_CAFE, 0, 0));
`else
        vecs.push_back(mk(0, 2'd2, 1, 64'h0E, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'd1, 0, 64'h03, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd2, 0, 64'h0E, 64'hCAFE_BABE, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        // Reset state
        #1 rst = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", -1, 64'(req_ready), 64'd1);
        chk("rst_resp_valid", -1, 64'(resp_valid), 64'd0);
        chk("rst_bus_valid", -1, 64'(bus_valid), 64'd0);
        chk("rst_bus_addr", -1, bus_addr, 64'd0);
        chk("rst_bus_wstrb", -1, 64'(bus_wstrb), 64'd0);
        chk("rst_bus_wdata", -1, bus_wdata, 64'd0);
        chk("rst_resp_rdata", -1, resp_rdata, 64'd0);
        chk("rst32_req_ready", -1, 64'(s_req_ready), 64'd1);
        rst = 1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset in the middle of a stalled BEAT0
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 64'h40;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; req_addr = 0;
        chk("mid_bus_valid_before", 100, 64'(bus_valid), 64'd1);
        #2 rst = 0;
        #1;
        chk("mid_bus_valid_drop", 100, 64'(bus_valid), 64'd0);
        chk("mid_bus_addr_zero", 100, bus_addr, 64'd0);
        chk("mid_req_ready", 100, 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_resp", 100 + i, 64'(resp_valid), 64'd0);
            chk("mid_no_bus", 100 + i, 64'(bus_valid), 64'd0);
            chk("mid_ready_after", 100 + i, 64'(req_ready), 64'd1);
        end
        run_vec(vecs[0], 200);

        // XLEN=32: double is illegal, no bus beat
        @(negedge clk);
        s_req_valid = 1; s_req_size = 2'b11; s_req_addr = 32'h0; s_req_we = 0;
        @(posedge clk);
        @(negedge clk);
        s_req_valid = 0; s_req_size = 0;
        chk("x32_dbl_resp_valid", 300, 64'(s_resp_valid), 64'd1);
        chk("x32_dbl_err", 300, 64'(s_resp_err), 64'd1);
        chk("x32_dbl_rdata", 300, 64'(s_resp_rdata), 64'd0);
        chk("x32_dbl_no_bus", 300, 64'(s_bus_valid), 64'd0);
        @(negedge clk);
        chk("x32_dbl_pulse_end", 300, 64'(s_resp_valid), 64'd0);
        chk("x32_dbl_no_bus2", 300, 64'(s_bus_valid), 64'd0);

        // XLEN=32: signed half load at 0x6
        @(negedge clk);
        s_req_valid = 1; s_req_size = 2'b01; s_req_addr = 32'h6; s_req_unsigned = 0;
        @(posedge clk);
        @(negedge clk);
        s_req_valid = 0; s_req_size = 0; s_req_addr = 0;
        chk("x32_half_bus_valid", 301, 64'(s_bus_valid), 64'd1);
        chk("x32_half_bus_addr", 301, 64'(s_bus_addr), 64'h4);
        chk("x32_half_wstrb", 301, 64'(s_bus_wstrb), 64'd0);
        s_bus_ready = 1; s_bus_rdata = 32'h8001_0000;
        @(posedge clk);
        @(negedge clk);
        s_bus_ready = 0; s_bus_rdata = 0;
        chk("x32_half_resp_valid", 301, 64'(s_resp_valid), 64'd1);
        chk("x32_half_rdata", 301, 64'(s_resp_rdata), 64'hFFFF_8001);
        chk("x32_half_err", 301, 64'(s_resp_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
